// File: rtl/regbank_param.sv
// regbank_param: 2-read/1-write register bank that zeroes itself after reset.
// Define REGBANK_BYPASS_EN to forward same-cycle write data onto the read ports.
module regbank_param #(
   parameter int WIDTH      = 32,
   parameter int DEPTH_LOG2 = 5,
   parameter int ZERO_REG   = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DEPTH_LOG2-1:0] addra,
   output logic [WIDTH-1:0]      dataa,
   input  logic [DEPTH_LOG2-1:0] addrb,
   output logic [WIDTH-1:0]      datab,
   input  logic                  enc,
   input  logic [DEPTH_LOG2-1:0] addrc,
   input  logic [WIDTH-1:0]      datac,
   output logic                  ready
);
   localparam int DEPTH = 2 ** DEPTH_LOG2;
   typedef enum logic {CLEAR, READY} state_t;
   state_t                state, next_state;
   logic [DEPTH_LOG2-1:0] ptr;
   logic [WIDTH-1:0]      regs [DEPTH];
   logic [WIDTH-1:0]      rd_a, rd_b;
   logic                  wr_ok, zero_a, zero_b;
   assign ready = state == READY;
   always_comb begin
      next_state = (state == CLEAR && ptr == '1) ? READY : state;
      wr_ok = state == READY && enc && !(ZERO_REG != 0 && addrc == '0);
      zero_a = ZERO_REG != 0 && addra == '0;
      zero_b = ZERO_REG != 0 && addrb == '0;
`ifdef REGBANK_BYPASS_EN
      rd_a = zero_a ? '0 : (wr_ok && addra == addrc) ? datac : regs[addra];
      rd_b = zero_b ? '0 : (wr_ok && addrb == addrc) ? datac : regs[addrb];
`else
      rd_a = zero_a ? '0 : regs[addra];
      rd_b = zero_b ? '0 : regs[addrb];
`endif
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= CLEAR;
         ptr   <= '0;
         dataa <= '0;
         datab <= '0;
      end else begin
         state <= next_state;
         ptr   <= state == CLEAR ? ptr + 1'b1 : '0;
         dataa <= state == READY ? rd_a : '0;
         datab <= state == READY ? rd_b : '0;
      end
   end
   // Storage is never reset directly; the sweep does the zeroing.
   always_ff @(posedge clock) begin
      if (!reset && state == CLEAR)
         regs[ptr] <= '0;
      else if (!reset && wr_ok)
         regs[addrc] <= datac;
   end
endmodule

// File: tb/tb_regbank_param.sv
// tb_regbank_param: directed checks of sweep, read/write, zero register and bypass.
module tb_regbank_param;
   logic        clock = 1'b0;
   logic        reset, enc, ready;
   logic [4:0]  addra, addrb, addrc;
   logic [31:0] dataa, datab, datac;
   int          checks = 0;
   int          errors = 0;
   int          n;
   logic [31:0] same_exp;

   regbank_param dut (
      .clock(clock), .reset(reset), .addra(addra), .dataa(dataa),
      .addrb(addrb), .datab(datab), .enc(enc), .addrc(addrc),
      .datac(datac), .ready(ready)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_ready();
      n = 0;
      while (!ready && n < 100) begin
         step();
         n++;
      end
   endtask

   initial begin
`ifdef REGBANK_BYPASS_EN
      same_exp = 32'hA5A5A5A5;
`else
      same_exp = 32'h00000001;
`endif
      reset = 1'b1; enc = 1'b0; addra = '0; addrb = '0; addrc = '0; datac = '0;
      step();
      step();
      check("reset_ready", {31'd0, ready}, 32'd0);
      check("reset_dataa", dataa, 32'd0);
      check("reset_datab", datab, 32'd0);
      reset = 1'b0;
      enc = 1'b1; addrc = 5'd3; datac = 32'hFFFFFFFF;
      wait_ready();
      enc = 1'b0;
      check("sweep_cycles", n, 32);
      check("sweep_ready", {31'd0, ready}, 32'd1);
      addra = 5'd3; addrb = 5'd31;
      step();
      check("clear_write_ignored", dataa, 32'd0);
      check("cleared_31", datab, 32'd0);
      enc = 1'b1; addrc = 5'd5; datac = 32'hDEADBEEF;
      step();
      enc = 1'b0; addra = 5'd5; addrb = 5'd5;
      step();
      check("wr_rd_a", dataa, 32'hDEADBEEF);
      check("wr_rd_b", datab, 32'hDEADBEEF);
      enc = 1'b1; addrc = 5'd0; datac = 32'h12345678; addra = 5'd0;
      step();
      check("zero_same_cycle", dataa, 32'd0);
      enc = 1'b0;
      step();
      check("zero_reg", dataa, 32'd0);
      enc = 1'b1; addrc = 5'd7; datac = 32'h00000001;
      step();
      datac = 32'hA5A5A5A5; addra = 5'd7; addrb = 5'd7;
      step();
      check("same_cycle_a", dataa, same_exp);
      check("same_cycle_b", datab, same_exp);
      enc = 1'b0;
      step();
      check("after_write_7", dataa, 32'hA5A5A5A5);
      enc = 1'b1; addrc = 5'd9; datac = 32'h13579BDF;
      step();
      enc = 1'b0; addra = 5'd9; addrb = 5'd5;
      step();
      check("rd_9", dataa, 32'h13579BDF);
      check("rd_5", datab, 32'hDEADBEEF);
      check("ready_held", {31'd0, ready}, 32'd1);
      reset = 1'b1;
      step();
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_dataa", dataa, 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) step();
      check("mid_sweep_ready", {31'd0, ready}, 32'd0);
      check("mid_sweep_dataa", dataa, 32'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      wait_ready();
      check("resweep_cycles", n, 32);
      step();
      check("resweep_9", dataa, 32'd0);
      check("resweep_5", datab, 32'd0);
      addra = 5'd7; addrb = 5'd31;
      step();
      check("resweep_7", dataa, 32'd0);
      check("resweep_31", datab, 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/regbank_param.md
REGBANK_PARAM -- requirements
Module: regbank_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the data width of every register and data port.
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 5, giving 2**DEPTH_LOG2 registers.
REQ-003 The block SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads as zero and ignores writes.
REQ-004 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port addra, input, DEPTH_LOG2, read port A address.
REQ-007 The block SHALL have port dataa, output, WIDTH, registered read port A data.
REQ-008 The block SHALL have port addrb, input, DEPTH_LOG2, read port B address.
REQ-009 The block SHALL have port datab, output, WIDTH, registered read port B data.
REQ-010 The block SHALL have port enc, input, 1, write enable for port C.
REQ-011 The block SHALL have port addrc, input, DEPTH_LOG2, write address.
REQ-012 The block SHALL have port datac, input, WIDTH, write data.
REQ-013 The block SHALL have port ready, output, 1, high when the clear sweep is done and accesses are live.

Function
REQ-014 The block SHALL implement a two-state machine: CLEAR (sweeping) and READY.
REQ-015 In CLEAR, the block SHALL write zero to register ptr each cycle, then increment ptr.
REQ-016 CLEAR SHALL take exactly 2**DEPTH_LOG2 cycles; after the edge clearing the last register, the state SHALL become READY and ptr SHALL wrap to 0.
REQ-017 In CLEAR, ready SHALL be 0, enc SHALL be ignored, and dataa/datab SHALL load 0.
REQ-018 In READY, ready SHALL be 1 and the state SHALL stay READY until reset.
REQ-019 In READY, each rising edge SHALL load dataa with registers[addra] and datab with registers[addrb]; read latency is 1 cycle.
REQ-020 In READY, with enc=1, the block SHALL write datac to registers[addrc] at the rising edge.
REQ-021 With ZERO_REG=1, a read of address 0 SHALL return 0 and a write to address 0 SHALL have no effect.
REQ-022 If addra equals addrb, both ports SHALL return identical data in the same cycle.
REQ-023 With simultaneous write and read of the same address, the behaviour SHALL be as defined under Configuration.

Reset
REQ-024 While reset=1 at a rising edge, the block SHALL set state to CLEAR, ptr to 0, ready to 0, and dataa and datab to 0.
REQ-025 Register contents SHALL NOT be modified by reset itself; zeroing happens only through the CLEAR sweep after reset deasserts.
REQ-026 Reset asserted during CLEAR or READY SHALL restart the sweep from ptr=0.
REQ-027 After power-up without reset, outputs SHALL be undefined until the first reset.

Configuration
REQ-028 With macro REGBANK_BYPASS_EN defined, a READY-state read whose address equals addrc with enc=1 SHALL load datac into the output; register 0 is excluded when ZERO_REG=1.
REQ-029 Without REGBANK_BYPASS_EN, such a read SHALL load the old register contents; the new value SHALL be visible from the next read.

Verification
REQ-030 Scenario, reset then sweep: assert reset for 2 cycles, then deassert -> ready=0 for exactly 32 cycles, then 1; a read of any address returns 0x00000000.
REQ-031 Scenario, write then read: enc=1, addrc=5, datac=0xDEADBEEF; next cycle addra=5, addrb=5 -> one edge later dataa=datab=0xDEADBEEF.
REQ-032 Scenario, zero register: write 0x12345678 to addrc=0; read addra=0 -> dataa=0x00000000 (ZERO_REG=1).
REQ-033 Scenario, same-cycle write and read: enc=1, addrc=7, datac=0xA5A5A5A5, addra=7, old value 0x1 -> dataa=0xA5A5A5A5 with REGBANK_BYPASS_EN, 0x00000001 without.
REQ-034 Scenario, write during CLEAR: enc=1, addrc=3, datac=0xFFFFFFFF while ready=0 -> after ready=1, reading 3 gives 0x00000000.
REQ-035 Scenario, mid-sweep reset: assert reset at sweep cycle 10 -> ready stays 0 for 32 full cycles after the second deassertion.
